// File: rtl/audio_pkg.sv
// Shared types and constants for the alarm-clock audio path.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam sample_t    SILENCE      = 16'h0000;
  localparam logic [7:0] UNDERRUN_MAX = 8'd255;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock chain: mclk and sclk dividers, the bit counter, lrclk, and the
// bit/frame/fetch strobes the scheduler is sequenced from.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int MCLK_HALF = 4,
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic clk,
  input  logic rst,
  output logic clk_mclk,
  output logic clk_sclk,
  output logic clk_lrclk,
  output logic bit_tick,
  output logic frame_start,
  output logic fetch_tick
);

  localparam int SC_LEN     = MCLK_HALF * SCLK_DIV;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int MC_W       = $clog2(MCLK_HALF + 1);
  localparam int SC_W       = $clog2(SC_LEN + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [MC_W-1:0]  MC_LAST    = MC_W'(MCLK_HALF - 1);
  localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(SC_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] FETCH_PREV = BIT_W'(SLOT_BITS + SLOT_BITS / 2 - 1);
  localparam logic [BIT_W-1:0] RIGHT_1ST  = BIT_W'(SLOT_BITS);

  logic [MC_W-1:0]  mc_cnt;
  logic [SC_W-1:0]  sc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_next;

  // Strobes are decoded from the current counters so that every register
  // moved by an event (bit_cnt, lrclk, pdata, i2s_en) updates on the same edge.
  assign bit_tick    = (sc_cnt == SC_LAST) && clk_sclk;
  assign bit_next    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
  assign frame_start = bit_tick && (bit_cnt == BIT_LAST);
  assign fetch_tick  = bit_tick && (bit_cnt == FETCH_PREV);

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_cnt    <= '0;
      sc_cnt    <= '0;
      bit_cnt   <= '0;
      clk_mclk  <= 1'b0;
      clk_sclk  <= 1'b0;
      clk_lrclk <= 1'b0;
    end else begin
      if (mc_cnt == MC_LAST) begin
        mc_cnt   <= '0;
        clk_mclk <= ~clk_mclk;
      end else begin
        mc_cnt <= mc_cnt + 1'b1;
      end
      if (sc_cnt == SC_LAST) begin
        sc_cnt   <= '0;
        clk_sclk <= ~clk_sclk;
      end else begin
        sc_cnt <= sc_cnt + 1'b1;
      end
      if (bit_tick) begin
        bit_cnt   <= bit_next;
        clk_lrclk <= (bit_next >= RIGHT_1ST);
      end
    end
  end

endmodule

// File: rtl/i2s_audio_sched.sv
// Pmod I2S sequencing controller: clock chain, round-robin sample fetch,
// frame-aligned enable. Optional macro AUDIO_VOLUME_EN adds the vol shifter.
module i2s_audio_sched
  import audio_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MCLK_HALF = 4,
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*SAMPLE_W-1:0] req_data,
`ifdef AUDIO_VOLUME_EN
  input  logic [2:0]               vol,
`endif
  output logic [NREQ-1:0]          req_ready,
  output logic                     clk_mclk,
  output logic                     clk_sclk,
  output logic                     clk_lrclk,
  output logic                     i2s_en,
  output logic [SAMPLE_W-1:0]      pdata,
  output logic [1:0]               grant_id,
  output logic [7:0]               underrun_cnt
);

  // Handshake: req_ready[i] is high only in the fetch-tick cycle that
  // requester i wins; the sample transfers on that edge (valid && ready).
  // A requester may drop valid at any time and is owed nothing.

  logic       bit_tick;
  logic       frame_start;
  logic       fetch_tick;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] idx;
  logic [1:0] ptr_next;
  logic       found;
  logic [3:0] valid_ext;
  logic [3:0] grant_oh;
  sample_t    req_arr [4];
  sample_t    captured;

  i2s_clkgen #(
    .MCLK_HALF (MCLK_HALF),
    .SCLK_DIV  (SCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .clk_mclk    (clk_mclk),
    .clk_sclk    (clk_sclk),
    .clk_lrclk   (clk_lrclk),
    .bit_tick    (bit_tick),
    .frame_start (frame_start),
    .fetch_tick  (fetch_tick)
  );

  // Requesters are widened to four slots so the rotating index is always 2 bits.
  always_comb begin
    valid_ext = '0;
    idx       = '0;
    found     = 1'b0;
    win       = ptr;
    for (int i = 0; i < 4; i++) req_arr[i] = SILENCE;
    for (int i = 0; i < NREQ; i++) begin
      valid_ext[i] = req_valid[i];
      req_arr[i]   = req_data[SAMPLE_W*i +: SAMPLE_W];
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = 2'((int'(ptr) + k) % NREQ);
      if (!found && valid_ext[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef AUDIO_VOLUME_EN
  assign captured = req_arr[win] >>> vol;
`else
  assign captured = req_arr[win];
`endif

  assign ptr_next  = 2'((int'(win) + 1) % NREQ);
  assign grant_oh  = 4'b0001 << win;
  assign req_ready = (fetch_tick && found && !rst) ? grant_oh[NREQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (bit_tick || !(fetch_tick || frame_start));
      assert (!(fetch_tick && frame_start));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      grant_id     <= '0;
      pdata        <= SILENCE;
      underrun_cnt <= '0;
      i2s_en       <= 1'b0;
    end else begin
      if (frame_start) i2s_en <= enable;
      if (fetch_tick) begin
        if (found) begin
          pdata    <= captured;
          grant_id <= win;
          ptr      <= ptr_next;
        end else begin
          pdata <= SILENCE;
          if (underrun_cnt != UNDERRUN_MAX) underrun_cnt <= underrun_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_sched.sv
// Bench for i2s_audio_sched: a default-parameter unit and a small fast-frame
// unit (3 requesters), each checked every cycle against a closed-form model.
module tb_i2s_audio_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- unit 0: defaults, unit 1: NREQ=3, tiny frame
  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic [1:0]  val0 = '0;
  logic [2:0]  val1 = '0;
  logic [31:0] dat0 = '0;
  logic [47:0] dat1 = '0;
  logic [2:0]  vol0 = '0, vol1 = '0;

  logic [1:0]  rr0;
  logic [2:0]  rr1;
  logic        mclk0, mclk1, sclk0, sclk1, lr0, lr1, ie0, ie1;
  logic [15:0] pd0, pd1;
  logic [1:0]  gid0, gid1;
  logic [7:0]  und0, und1;

  i2s_audio_sched dut0 (
    .clk(clk), .rst(rst0), .enable(en0), .req_valid(val0), .req_data(dat0),
`ifdef AUDIO_VOLUME_EN
    .vol(vol0),
`endif
    .req_ready(rr0), .clk_mclk(mclk0), .clk_sclk(sclk0), .clk_lrclk(lr0),
    .i2s_en(ie0), .pdata(pd0), .grant_id(gid0), .underrun_cnt(und0)
  );

  i2s_audio_sched #(.NREQ(3), .MCLK_HALF(1), .SCLK_DIV(2), .SLOT_BITS(16)) dut1 (
    .clk(clk), .rst(rst1), .enable(en1), .req_valid(val1), .req_data(dat1),
`ifdef AUDIO_VOLUME_EN
    .vol(vol1),
`endif
    .req_ready(rr1), .clk_mclk(mclk1), .clk_sclk(sclk1), .clk_lrclk(lr1),
    .i2s_en(ie1), .pdata(pd1), .grant_id(gid1), .underrun_cnt(und1)
  );

  // ---------------- parameters and input access per unit
  function automatic int p_n(input int u);  return (u == 0) ? 2 : 3;  endfunction
  function automatic int p_mh(input int u); return (u == 0) ? 4 : 1;  endfunction
  function automatic int p_sd(input int u); return (u == 0) ? 4 : 2;  endfunction
  function automatic int p_sb(input int u); return (u == 0) ? 32 : 16; endfunction
  function automatic int half_sc(input int u); return p_mh(u) * p_sd(u); endfunction
  function automatic int bit_len(input int u); return 2 * half_sc(u); endfunction
  function automatic int frame_len(input int u); return 2 * p_sb(u) * bit_len(u); endfunction
  function automatic int left_len(input int u); return p_sb(u) * bit_len(u); endfunction
  function automatic int fetch_pos(input int u);
    return (p_sb(u) + p_sb(u) / 2) * bit_len(u);
  endfunction

  function automatic logic cur_rst(input int u); return (u == 0) ? rst0 : rst1; endfunction
  function automatic logic cur_en(input int u);  return (u == 0) ? en0 : en1;   endfunction
  function automatic logic [3:0] cur_val(input int u);
    return (u == 0) ? 4'(val0) : 4'(val1);
  endfunction
  function automatic logic [63:0] cur_dat(input int u);
    return (u == 0) ? 64'(dat0) : 64'(dat1);
  endfunction
  function automatic logic [2:0] vol_of(input int u);
`ifdef AUDIO_VOLUME_EN
    return (u == 0) ? vol0 : vol1;
`else
    return (u == 0) ? 3'd0 : 3'd0;
`endif
  endfunction

  function automatic logic [31:0] dut_out(input int u, input int sel);
    case (sel)
      0: return (u == 0) ? 32'(mclk0) : 32'(mclk1);
      1: return (u == 0) ? 32'(sclk0) : 32'(sclk1);
      2: return (u == 0) ? 32'(lr0)   : 32'(lr1);
      3: return (u == 0) ? 32'(ie0)   : 32'(ie1);
      4: return (u == 0) ? 32'(pd0)   : 32'(pd1);
      5: return (u == 0) ? 32'(gid0)  : 32'(gid1);
      6: return (u == 0) ? 32'(und0)  : 32'(und1);
      7: return (u == 0) ? 32'(rr0)   : 32'(rr1);
      default: return '0;
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0: return "clk_mclk";
      1: return "clk_sclk";
      2: return "clk_lrclk";
      3: return "i2s_en";
      4: return "pdata";
      5: return "grant_id";
      6: return "underrun_cnt";
      default: return "req_ready";
    endcase
  endfunction

  task automatic check(input string name, input int u, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s unit%0d cycle %0d: got %0h, expected %0h", name, u, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model: t = clock edges since reset release
  int          m_t   [2];
  int          m_ptr [2];
  int          m_gid [2];
  int          m_und [2];
  logic        m_en  [2];
  logic [15:0] m_pd  [2];
  bit          chk_on[2];

  // Round robin: first valid requester at or after the pointer, -1 if none.
  function automatic int pick(input int u);
    logic [3:0] v;
    v = cur_val(u);
    for (int k = 0; k < p_n(u); k++) begin
      int i;
      i = (m_ptr[u] + k) % p_n(u);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] shape(input logic [2:0] v, input logic [15:0] d);
    logic signed [15:0] s;
    s = d;
    return 16'(s >>> v);
  endfunction

  task automatic model_step(input int u);
    int e, w;
    logic [63:0] d;
    if (cur_rst(u)) begin
      m_t[u] = 0; m_ptr[u] = 0; m_gid[u] = 0; m_und[u] = 0;
      m_en[u] = 1'b0; m_pd[u] = 16'h0; chk_on[u] = 1'b1;
    end else begin
      e = m_t[u] + 1;
      if (e % frame_len(u) == fetch_pos(u)) begin
        w = pick(u);
        d = cur_dat(u);
        if (w >= 0) begin
          m_pd[u]  = shape(vol_of(u), d[16*w +: 16]);
          m_gid[u] = w;
          m_ptr[u] = (w + 1) % p_n(u);
        end else begin
          m_pd[u] = 16'h0;
          if (m_und[u] < 255) m_und[u]++;
        end
      end
      if (e % frame_len(u) == 0) m_en[u] = cur_en(u);
      m_t[u] = e;
    end
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) model_step(u);
  end

  // Compare process: registered outputs and the accept pulse, every cycle.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (chk_on[u]) begin
        logic [31:0] exp [8];
        int e, w;
        e = m_t[u];
        exp[0] = 32'((e / p_mh(u)) % 2);
        exp[1] = 32'((e / half_sc(u)) % 2);
        exp[2] = 32'((e % frame_len(u)) >= left_len(u));
        exp[3] = 32'(m_en[u]);
        exp[4] = 32'(m_pd[u]);
        exp[5] = 32'(m_gid[u]);
        exp[6] = 32'(m_und[u]);
        exp[7] = '0;
        if (!cur_rst(u) && ((e + 1) % frame_len(u) == fetch_pos(u))) begin
          w = pick(u);
          if (w >= 0) exp[7] = 32'(1) << w;
        end
        for (int k = 0; k < 8; k++) check(sig_name(k), u, dut_out(u, k), exp[k]);
      end
    end
  end

  // ---------------- driver tasks
  logic [31:0] exp_q[$];
  bit done0 = 1'b0, done1 = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sig0(input int sel, input logic lvl, input string what);
    int c;
    logic [31:0] s;
    c = 0;
    s = dut_out(0, sel);
    while (s[0] !== lvl && c < 5000) begin
      tick(1);
      c++;
      s = dut_out(0, sel);
    end
    if (c >= 5000) check({what, "_timeout"}, 0, 32'(c), 32'd0);
  endtask

  task automatic fall0(input int sel, input string what);
    wait_sig0(sel, 1'b1, what);
    wait_sig0(sel, 1'b0, what);
  endtask

  task automatic wait_accept0(output int n);
    n = 0;
    while (rr0 == 2'b00 && n < 3000) begin
      tick(1);
      n++;
    end
    if (n >= 3000) check("accept_timeout", 0, 32'(n), 32'd0);
  endtask

  task automatic meas0(input int sel, output int period, output int high);
    int t0, t1;
    wait_sig0(sel, 1'b0, "meas");
    wait_sig0(sel, 1'b1, "meas");
    t0 = cyc;
    wait_sig0(sel, 1'b0, "meas");
    t1 = cyc;
    wait_sig0(sel, 1'b1, "meas");
    period = cyc - t0;
    high   = t1 - t0;
  endtask

  // ---------------- unit 0 scenario
  initial begin
    int n, per, hi;
    rst0 = 1'b1;
    tick(3);
    check("rst_pdata", 0, 32'(pd0), 32'h0);
    check("rst_sclk", 0, 32'(sclk0), 32'h0);
    check("rst_grant", 0, 32'(gid0), 32'h0);

    // Both valid: grants alternate starting at requester 0.
    val0 = 2'b11;
    dat0 = {16'h2222, 16'h1111};
    rst0 = 1'b0;
    exp_q.push_back(32'h1111); exp_q.push_back(32'h2222);
    exp_q.push_back(32'h1111); exp_q.push_back(32'h2222);
    for (int k = 0; k < 4; k++) begin
      wait_accept0(n);
      if (k == 0) check("first_accept_edge", 0, 32'(n + 1), 32'd1536);
      check("alt_ready_onehot", 0, 32'(rr0), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick(1);
      check("alt_ready_width", 0, 32'(rr0), 32'h0);
      check("alt_pdata", 0, 32'(pd0), exp_q.pop_front());
      check("alt_grant", 0, 32'(gid0), 32'(k % 2));
    end

    meas0(0, per, hi);
    check("mclk_period", 0, 32'(per), 32'd8);
    meas0(1, per, hi);
    check("sclk_period", 0, 32'(per), 32'd32);
    check("sclk_high", 0, 32'(hi), 32'd16);
    meas0(2, per, hi);
    check("lrclk_period", 0, 32'(per), 32'd2048);
    check("lrclk_high", 0, 32'(hi), 32'd1024);

    // Enable raised mid-left-slot, later dropped mid-frame.
    fall0(2, "lr_fall");
    tick(300);
    en0 = 1'b1;
    wait_sig0(2, 1'b1, "lr_rise");
    check("en_gated_midframe", 0, 32'(ie0), 32'h0);
    wait_sig0(2, 1'b0, "lr_fall");
    check("en_at_frame_start", 0, 32'(ie0), 32'h1);
    tick(500);
    en0 = 1'b0;
    wait_sig0(2, 1'b1, "lr_rise");
    check("en_holds_frame", 0, 32'(ie0), 32'h1);
    wait_sig0(2, 1'b0, "lr_fall");
    check("en_drop_at_frame_start", 0, 32'(ie0), 32'h0);

    // Reset in the very cycle the accept pulse would fire.
    en0 = 1'b1;
    fall0(2, "lr_fall");
    wait_sig0(2, 1'b1, "lr_rise");
    tick(511);
    rst0 = 1'b1;
    #1;
    check("rst_blocks_ready", 0, 32'(rr0), 32'h0);
    tick(1);
    check("rst_mid_pdata", 0, 32'(pd0), 32'h0);
    check("rst_mid_en", 0, 32'(ie0), 32'h0);
    check("rst_mid_lrclk", 0, 32'(lr0), 32'h0);
    check("rst_mid_grant", 0, 32'(gid0), 32'h0);
    rst0 = 1'b0;
    wait_accept0(n);
    check("accept_after_reset", 0, 32'(n + 1), 32'd1536);
    tick(1);

`ifdef AUDIO_VOLUME_EN
    vol0 = 3'd2;
    dat0 = {16'h8000, 16'h8000};
    wait_accept0(n);
    tick(1);
    check("vol2_neg", 0, 32'(pd0), 32'hE000);
    vol0 = 3'd0;
    dat0 = {16'h7FFF, 16'h7FFF};
    wait_accept0(n);
    tick(1);
    check("vol0_pos", 0, 32'(pd0), 32'h7FFF);
`endif

    // Random valids, data and enable against the model.
    for (int c = 0; c < 6 * 2048; c++) begin
      val0 = 2'($urandom_range(0, 3));
      dat0 = $urandom;
      vol0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) en0 = ~en0;
      tick(1);
    end
    done0 = 1'b1;
  end

  // ---------------- unit 1 scenario
  initial begin
    rst1 = 1'b1;
    tick(2);
    rst1 = 1'b0;
    for (int c = 0; c < 30 * 128; c++) begin
      val1 = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      dat1 = {16'($urandom), 32'($urandom)};
      vol1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) en1 = ~en1;
      tick(1);
    end
    // Starved: silence and a saturating underrun count.
    rst1 = 1'b1;
    val1 = 3'b000;
    tick(1);
    rst1 = 1'b0;
    tick(10 * 128);
    check("underrun_10_frames", 1, 32'(und1), 32'd10);
    tick(300 * 128);
    check("underrun_saturated", 1, 32'(und1), 32'd255);
    check("underrun_silence", 1, 32'(pd1), 32'h0);
    done1 = 1'b1;
  end

  // ---------------- final report
  initial begin
    int c;
    c = 0;
    while (!(done0 && done1) && c < 90000) begin
      @(posedge clk);
      c++;
    end
    if (!(done0 && done1)) check("scenario_timeout", 0, 32'({done1, done0}), 32'h3);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
